// File: rtl/multdiv_sequencer_pkg.sv
// Shared types and constants for the mul/div sequencer: FSM state encoding,
// decoded ALU opcodes and the status-register exception codes.
package multdiv_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_WB     = 2'd3
    } md_state_e;

    // Decoded R-type ALU opcodes that route to the iterative multdiv unit
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    // Exception reporting goes to the status register with an op-specific code
    localparam logic [REG_W-1:0]  RSTATUS_REG = 5'd30;
    localparam logic [DATA_W-1:0] RSTATUS_MUL = 32'd4;
    localparam logic [DATA_W-1:0] RSTATUS_DIV = 32'd5;

    // Status code written when the given operation raises an exception
    function automatic logic [DATA_W-1:0] rstatus_code(input logic [4:0] op);
        return (op == ALU_MUL) ? RSTATUS_MUL : RSTATUS_DIV;
    endfunction

endpackage

// File: rtl/multdiv_sequencer_if.sv
// Handshake bundle between the sequencer (master) and the iterative multdiv
// unit (slave): latched operands, launch pulses, and the result return path.
interface multdiv_sequencer_if;
    import multdiv_pkg::*;

    logic [DATA_W-1:0] md_a;
    logic [DATA_W-1:0] md_b;
    logic              ctrl_mult;
    logic              ctrl_div;
    logic              md_rdy;
    logic [DATA_W-1:0] md_result;
    logic              md_exception;

    // Sequencer side: drives operands and launch, receives completion
    modport master (
        output md_a,
        output md_b,
        output ctrl_mult,
        output ctrl_div,
        input  md_rdy,
        input  md_result,
        input  md_exception
    );

    // Multdiv unit side
    modport slave (
        input  md_a,
        input  md_b,
        input  ctrl_mult,
        input  ctrl_div,
        output md_rdy,
        output md_result,
        output md_exception
    );

endinterface

// File: rtl/multdiv_sequencer_timeout.sv
// WAIT-state cycle counter. Cleared during LAUNCH, counts while enabled and
// flags terminal count when it reaches LIMIT-1; it holds there rather than
// wrapping so a late enable can never alias back to a small count.
module md_timeout_counter #(
    parameter int LIMIT = 40
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int              CNT_W  = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count;

    assign tc = (count == TC_VAL);

    // Count WAIT cycles; clear has priority so every launch starts from zero
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !tc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences a decoded mul/div through the iterative multdiv unit: captures
// operands, issues a one-cycle launch pulse, waits for the result (with a
// timeout that forces an exception), then performs a single-cycle register
// write-back. Fetch/decode is stalled for the duration of the operation.
module multdiv_sequencer
    import multdiv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start_mul,
    input  logic                start_div,
    input  logic [DATA_W-1:0]   rs_data,
    input  logic [DATA_W-1:0]   rt_data,
    input  logic [REG_W-1:0]    rd,
    multdiv_sequencer_if.master md,
    output logic                stall,
    output logic                busy,
    output logic                wb_en,
    output logic [REG_W-1:0]    wb_reg,
    output logic [DATA_W-1:0]   wb_data
);

    md_state_e         state;
    md_state_e         state_next;

    logic [DATA_W-1:0] a_lat;
    logic [DATA_W-1:0] b_lat;
    logic [REG_W-1:0]  rd_lat;
    logic [4:0]        op_lat;
    logic [DATA_W-1:0] result_lat;
    logic              exc_lat;

    logic              start_any;
    logic              cnt_clear;
    logic              cnt_enable;
    logic              cnt_tc;

    assign start_any  = start_mul | start_div;
    assign cnt_clear  = (state == ST_LAUNCH);
    assign cnt_enable = (state == ST_WAIT);

    md_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .tc      (cnt_tc)
    );

    // Next-state logic; a ready result takes priority over the timeout
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start_any) state_next = ST_LAUNCH;
            ST_LAUNCH: state_next = ST_WAIT;
            ST_WAIT:   if (md.md_rdy || cnt_tc) state_next = ST_WB;
            ST_WB:     state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand/destination capture in IDLE; multiply wins when both starts fire
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_lat  <= '0;
            b_lat  <= '0;
            rd_lat <= '0;
            op_lat <= '0;
        end else if (state == ST_IDLE && start_any) begin
            a_lat  <= rs_data;
            b_lat  <= rt_data;
            rd_lat <= rd;
            op_lat <= start_mul ? ALU_MUL : ALU_DIV;
        end
    end

    // Result capture in WAIT; a timeout without md_rdy forces the exception flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_lat <= '0;
            exc_lat    <= 1'b0;
        end else if (state == ST_IDLE && start_any) begin
            result_lat <= '0;
            exc_lat    <= 1'b0;
        end else if (state == ST_WAIT) begin
            if (md.md_rdy) begin
                result_lat <= md.md_result;
                exc_lat    <= md.md_exception;
            end else if (cnt_tc) begin
                exc_lat    <= 1'b1;
            end
        end
    end

    assign md.md_a      = a_lat;
    assign md.md_b      = b_lat;
    assign md.ctrl_mult = (state == ST_LAUNCH) && (op_lat == ALU_MUL);
    assign md.ctrl_div  = (state == ST_LAUNCH) && (op_lat == ALU_DIV);

    assign busy = (state != ST_IDLE);

    // Stall decode as soon as a start is seen, through LAUNCH and WAIT; the
    // write-back cycle releases the pipeline so the next instruction can issue
    always_comb begin
        stall = 1'b0;
        if (reset_n) begin
            case (state)
                ST_IDLE:   stall = start_any;
                ST_LAUNCH: stall = 1'b1;
                ST_WAIT:   stall = 1'b1;
                default:   stall = 1'b0;
            endcase
        end
    end

    // Write-back: result to rd (suppressed for r0) or status code to RSTATUS
    always_comb begin
        wb_en   = 1'b0;
        wb_reg  = '0;
        wb_data = '0;
        if (state == ST_WB) begin
            if (exc_lat) begin
                wb_en   = 1'b1;
                wb_reg  = RSTATUS_REG;
                wb_data = rstatus_code(op_lat);
            end else begin
                wb_en   = (rd_lat != '0);
                wb_reg  = rd_lat;
                wb_data = result_lat;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Scoreboard bench for multdiv_sequencer: each operation pushes its expected
// write-back, a negedge monitor pops and compares when the DUT writes back.
module tb_multdiv_sequencer;
    import multdiv_pkg::*;

    localparam int TIMEOUT = 40;

    typedef struct {
        logic        en;
        logic [4:0]  r;
        logic [31:0] d;
        bit          full;
    } wb_exp_t;

    logic        clock;
    logic        reset_n;
    logic        start_mul;
    logic        start_div;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [4:0]  rd;
    logic        stall;
    logic        busy;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;
    int mult_pulses = 0;
    int div_pulses = 0;
    wb_exp_t sb[$];

    multdiv_sequencer_if md_if ();

    multdiv_sequencer #(
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start_mul (start_mul),
        .start_div (start_div),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .rd        (rd),
        .md        (md_if),
        .stall     (stall),
        .busy      (busy),
        .wb_en     (wb_en),
        .wb_reg    (wb_reg),
        .wb_data   (wb_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: count launch pulses and score every write-back cycle
    always @(negedge clock) begin
        if (reset_n) begin
            if (md_if.ctrl_mult) mult_pulses++;
            if (md_if.ctrl_div)  div_pulses++;
            if (busy && !stall) begin
                if (sb.size() == 0) begin
                    check_val("unexpected_wb", {31'd0, wb_en}, 32'd0);
                end else begin
                    wb_exp_t e;
                    e = sb.pop_front();
                    check_val("wb_en", {31'd0, wb_en}, {31'd0, e.en});
                    if (e.full) begin
                        check_val("wb_reg", {27'd0, wb_reg}, {27'd0, e.r});
                        check_val("wb_data", wb_data, e.d);
                    end
                end
            end else if (wb_en) begin
                check_val("wb_en_outside_wb", {31'd0, wb_en}, 32'd0);
            end
        end
    end

    // One complete operation; rdy_after = WAIT cycle (1-based) with md_rdy, 0 = never
    task automatic run_op(input bit sm, input bit sd, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] r,
                          input int rdy_after, input logic [31:0] res, input bit exc);
        wb_exp_t e;
        int n;
        int m0;
        int d0;
        int hold_bad;
        int exp_wait;
        bit seen;
        exp_wait = (rdy_after == 0) ? TIMEOUT : rdy_after;
        if (exc || rdy_after == 0) e = '{1'b1, 5'd30, (sm ? 32'd4 : 32'd5), 1'b1};
        else if (r == 5'd0)        e = '{1'b0, 5'd0, 32'd0, 1'b0};
        else                       e = '{1'b1, r, res, 1'b1};
        sb.push_back(e);
        m0 = mult_pulses;
        d0 = div_pulses;
        start_mul = sm;
        start_div = sd;
        rs_data = a;
        rt_data = b;
        rd = r;
        #1;
        check_val("stall_on_start", {31'd0, stall}, 32'd1);
        @(posedge clock); #1;
        start_mul = 0;
        start_div = 0;
        rs_data = $urandom;
        rt_data = $urandom;
        rd = 5'($urandom);
        md_if.md_rdy = 1'b1;
        md_if.md_result = 32'hdeadbeef;
        md_if.md_exception = 1'b1;
        check_val("launch_mult", {31'd0, md_if.ctrl_mult}, {31'd0, sm});
        check_val("launch_div", {31'd0, md_if.ctrl_div}, {31'd0, (!sm && sd)});
        check_val("md_a", md_if.md_a, a);
        check_val("md_b", md_if.md_b, b);
        check_val("stall_launch", {31'd0, stall}, 32'd1);
        @(posedge clock); #1;
        md_if.md_rdy = 1'b0;
        md_if.md_result = 32'd0;
        md_if.md_exception = 1'b0;
        n = 0;
        seen = 0;
        hold_bad = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (busy && !stall) begin
                seen = 1;
            end else begin
                n++;
                if (md_if.md_a !== a || md_if.md_b !== b || !busy || !stall) hold_bad++;
                if (n == rdy_after) begin
                    md_if.md_rdy = 1'b1;
                    md_if.md_result = res;
                    md_if.md_exception = exc;
                end
                @(posedge clock); #1;
                md_if.md_rdy = 1'b0;
                md_if.md_result = 32'd0;
                md_if.md_exception = 1'b0;
            end
        end
        check_val("wb_seen", {31'd0, seen}, 32'd1);
        check_val("wait_cycles", n, exp_wait);
        check_val("wait_hold", hold_bad, 0);
        check_val("md_a_in_wb", md_if.md_a, a);
        start_mul = 1'b1;
        @(posedge clock); #1;
        check_val("wb_to_idle", {31'd0, busy}, 32'd0);
        start_mul = 1'b0;
        check_val("mult_pulses", mult_pulses - m0, (sm ? 1 : 0));
        check_val("div_pulses", div_pulses - d0, ((!sm && sd) ? 1 : 0));
        check_val("sb_drained", sb.size(), 0);
    endtask

    // Abort a divide with reset during WAIT: no write-back, no new launch
    task automatic reset_in_wait();
        int d0;
        int m0;
        d0 = div_pulses;
        m0 = mult_pulses;
        start_div = 1'b1;
        rs_data = 32'd50;
        rt_data = 32'd5;
        rd = 5'd9;
        @(posedge clock); #1;
        start_div = 1'b0;
        @(posedge clock); #1;
        repeat (4) begin
            @(posedge clock); #1;
        end
        check_val("busy_before_rst", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_stall", {31'd0, stall}, 32'd0);
        check_val("rst_wb_en", {31'd0, wb_en}, 32'd0);
        check_val("rst_md_a", md_if.md_a, 32'd0);
        check_val("rst_md_b", md_if.md_b, 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        md_if.md_rdy = 1'b1;
        md_if.md_result = 32'd10;
        @(posedge clock); #1;
        md_if.md_rdy = 1'b0;
        md_if.md_result = 32'd0;
        repeat (4) begin
            @(posedge clock); #1;
        end
        check_val("post_rst_busy", {31'd0, busy}, 32'd0);
        check_val("post_rst_div", div_pulses - d0, 1);
        check_val("post_rst_mult", mult_pulses - m0, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        start_mul = 1'b0;
        start_div = 1'b0;
        rs_data = 32'd0;
        rt_data = 32'd0;
        rd = 5'd0;
        md_if.md_rdy = 1'b0;
        md_if.md_result = 32'd0;
        md_if.md_exception = 1'b0;
        #12;
        check_val("reset_busy", {31'd0, busy}, 32'd0);
        check_val("reset_stall", {31'd0, stall}, 32'd0);
        check_val("reset_wb_en", {31'd0, wb_en}, 32'd0);
        check_val("reset_ctrl", {30'd0, md_if.ctrl_mult, md_if.ctrl_div}, 32'd0);
        check_val("reset_md_a", md_if.md_a, 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        run_op(1, 0, 32'd7,   32'd6,  5'd3,  32, 32'd42,     0);
        run_op(0, 1, 32'd9,   32'd0,  5'd4,  5,  32'd0,      1);
        run_op(1, 0, 32'd11,  32'd13, 5'd5,  0,  32'd0,      0);
        run_op(1, 1, 32'd3,   32'd4,  5'd7,  1,  32'h1234,   0);
        run_op(1, 0, 32'd9,   32'd11, 5'd0,  3,  32'd99,     0);
        run_op(0, 1, 32'd100, 32'd7,  5'd31, 10, 32'd14,     0);
        run_op(0, 1, 32'd8,   32'd2,  5'd6,  0,  32'd0,      0);
        run_op(1, 0, 32'hffff_ffff, 32'hffff_ffff, 5'd2, 39, 32'd1, 1);
        run_op(1, 0, 32'd5,   32'd5,  5'd8,  40, 32'd25,     0);
        reset_in_wait();
        run_op(0, 1, 32'd81,  32'd9,  5'd12, 2,  32'd9,      0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
